// File: rtl/rr_arbiter8_pkg.sv
// Shared arbiter definitions: requester count, index width, FSM state codes
// and the rotating priority scan reused by arbiters in this directory.
package rr_arbiter8_pkg;

    localparam int unsigned ARB_N  = 8;
    localparam int unsigned ARB_IW = 3;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Rotate req so bit ptr lands at position 0, pick the lowest set bit,
    // then rotate the offset back; the 3-bit add wraps 7->0 naturally.
    function automatic logic [ARB_IW-1:0] rr_pick(input logic [ARB_N-1:0]  req,
                                                  input logic [ARB_IW-1:0] ptr);
        logic [2*ARB_N-1:0] dbl;
        logic [ARB_N-1:0]   rot;
        logic [ARB_IW-1:0]  off;
        dbl = {req, req};
        rot = dbl[ptr +: ARB_N];
        off = '0;
        for (int unsigned j = ARB_N; j > 0; j--) begin
            if (rot[j-1]) off = ARB_IW'(j - 1);
        end
        return ptr + off;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the arbiter and its requesters.
interface rr_arbiter8_if;
    import rr_arbiter8_pkg::*;

    logic [ARB_N-1:0]  req;
    logic [ARB_N-1:0]  gnt;
    logic [ARB_IW-1:0] gnt_idx;
    logic              gnt_vld;
    logic              timeout;

    modport master (input req, output gnt, gnt_idx, gnt_vld, timeout);
    modport slave  (output req, input gnt, gnt_idx, gnt_vld, timeout);

endinterface

// File: rtl/rr_arbiter8_decoder3e.sv
// 3-to-8 decoder with enable; e is one-hot at index n when ena, else all zero.
module decoder3e
    import rr_arbiter8_pkg::*;
(
    input  logic [ARB_IW-1:0] n,
    input  logic              ena,
    output logic [ARB_N-1:0]  e
);

    always_comb begin
        e = '0;
        if (ena) e[n] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with bounded hold time; the grant
// vector is decoded straight from the registered holder index.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic          clk,
    input  logic          clrn,
    rr_arbiter8_if.master bus
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

    arb_state_t        state, state_nxt;
    logic [ARB_IW-1:0] ptr, ptr_nxt;
    logic [ARB_IW-1:0] idx, idx_nxt;
    logic              vld, vld_nxt;
    logic [CNT_W-1:0]  hold_cnt, cnt_nxt;
    logic              tmo, tmo_nxt;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= ARB_IDLE;
            ptr      <= '0;
            idx      <= '0;
            vld      <= 1'b0;
            hold_cnt <= '0;
            tmo      <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            idx      <= idx_nxt;
            vld      <= vld_nxt;
            hold_cnt <= cnt_nxt;
            tmo      <= tmo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = idx;
        vld_nxt   = vld;
        cnt_nxt   = hold_cnt;
        tmo_nxt   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (|bus.req) begin
                    idx_nxt   = rr_pick(bus.req, ptr);
                    vld_nxt   = 1'b1;
                    cnt_nxt   = HOLD_ONE;
                    state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (!bus.req[idx] || hold_cnt == HOLD_MAX) begin
                    vld_nxt   = 1'b0;
                    ptr_nxt   = idx + 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ARB_IDLE;
                    // Releasing with req still high can only be the hold limit.
                    tmo_nxt   = bus.req[idx];
                end else begin
                    cnt_nxt = hold_cnt + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        bus.gnt_idx = idx;
        bus.gnt_vld = vld;
        bus.timeout = tmo;
    end

    decoder3e u_dec (
        .n   (idx),
        .ena (vld),
        .e   (bus.gnt)
    );

endmodule
